hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage core (Fetch, Decode, Execute, Memory, Writeback). It drives the Execute-stage forwarding selects and the per-stage stall and flush strobes. It sequences multi-cycle Execute operations and data-memory wait states, and keeps saturating stall and flush event counters. The block sits beside the pipeline registers and consumes only registered pipeline-stage fields.

## Interface
Parameters:
- MC_LATENCY, 4: total cycles a multi-cycle op occupies Execute; legal range ≥ 2.
- CNT_W, 32: width of each event counter.

Ports:
- CLK  in  1  clock; rising edge.
- RESET  in  1  reset; asynchronous, active-high.
- RA1D, RA2D  in  4  source registers of the instruction in Decode.
- RA1E, RA2E  in  4  source registers of the instruction in Execute.
- WA3E, WA3M, WA3W  in  4  destination registers in Execute, Memory and Writeback.
- RegWriteE, RegWriteM, RegWriteW  in  1  destination-write enables.
- MemtoRegE  in  1  the instruction in Execute is a load.
- BranchTakenE  in  1  taken branch resolved in Execute (the Execute PCSrc output).
- MultiCycleE  in  1  the instruction in Execute needs MC_LATENCY cycles.
- MemReqM, MemReadyM  in  1  data-memory request and ready signals from the Memory stage.
- ForwardAE, ForwardBE  out  2  forwarding select: 00 register file, 01 ResultW, 10 ALUResultM.
- StallF, StallD, StallE, StallM  out  1  hold the pipeline register feeding that stage.
- FlushD, FlushE, FlushM, FlushW  out  1  force a bubble into that stage register.
- StallCycles  out  CNT_W  count of cycles with StallF=1; saturates.
- FlushEvents  out  CNT_W  count of taken-branch flushes; saturates.

## Operation
- Forwarding for operand A:
  - ForwardAE=10 if RegWriteM && WA3M==RA1E.
  - Else ForwardAE=01 if RegWriteW && WA3W==RA1E.
  - Else ForwardAE=00.
  - Memory has priority over Writeback.
- Forwarding for operand B: same rule using RA2E.
- Load-use hazard: LdStall = MemtoRegE && RegWriteE && (WA3E==RA1D || WA3E==RA2D).
- Memory wait: MemStall = MemReqM && !MemReadyM.
- Multi-cycle FSM: states IDLE and MULTI, with a down-counter Cnt.
  - IDLE with MultiCycleE=1 and MemStall=0: McStall=1, load Cnt=MC_LATENCY-2, go to MULTI.
  - MULTI with Cnt≠0: McStall=1. Decrement Cnt when MemStall=0.
  - MULTI with Cnt==0: McStall=0, so the op leaves Execute. Go to IDLE when MemStall=0. MultiCycleE is ignored in this cycle.
  - While MemStall=1, the state and Cnt are frozen.
- Output equations:
  - StallF = StallD = MemStall | LdStall | McStall.
  - StallE = MemStall | McStall.
  - StallM = MemStall.
  - FlushW = MemStall.
  - FlushM = McStall & !MemStall.
  - FlushE = !MemStall & (LdStall | BranchTakenE).
  - FlushD = !MemStall & BranchTakenE.
- Simultaneous events:
  - BranchTakenE together with LdStall: both flushes apply. The branch target fetch proceeds and the stall is overridden: StallF=StallD=0 when BranchTakenE && !McStall && !MemStall.
  - MemStall overrides everything. A branch held in Execute re-asserts its flush once MemStall drops.
- Counters:
  - StallCycles increments on every cycle with StallF=1.
  - FlushEvents increments on every cycle with FlushD=1.
  - Both hold at 2^CNT_W−1 once reached.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and the current FSM state. They are valid in the same cycle and have zero latency.
- Cnt, state and both counters update on the rising edge of CLK.
- A multi-cycle op asserts StallE for exactly MC_LATENCY−1 cycles when MemStall=0. Each MemStall cycle extends this by one.
- Back-to-back multi-cycle ops have no idle gap: the release cycle returns to IDLE, and the next op is recognised in the following cycle.
- Reset (asynchronous) applies immediately, including in the middle of a multi-cycle op:
  - state=IDLE, Cnt=0, StallCycles=0, FlushEvents=0.
  - The combinational outputs then follow the inputs. With all inputs at 0, every output is 0 and ForwardAE=ForwardBE=00.

## Structure
- Shared package hazard_pkg holds:
  - typedef fwd_sel_t, with FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - typedef mc_state_t, with IDLE and MULTI.
- One sub-module, fwd_unit: the combinational forwarding compare for a single operand, instantiated twice.
- Sequential logic is confined to the FSM, Cnt and the two counters.

## Test plan
- Forwarding: RegWriteM=1, WA3M=3, RegWriteW=1, WA3W=3, RA1E=3, RA2E=5 -> ForwardAE=10, ForwardBE=00. Then drop RegWriteM -> ForwardAE=01.
- Load-use: MemtoRegE=1, RegWriteE=1, WA3E=2, RA2D=2 -> StallF=StallD=FlushE=1 for one cycle, StallE=0. StallCycles increments by 1.
- Multi-cycle, MC_LATENCY=4: MultiCycleE high for 4 cycles -> StallE=1 and FlushM=1 in cycles 1–3, StallE=0 in cycle 4. State returns to IDLE after cycle 4.
- MemStall during MULTI: MemReadyM=0 for 2 cycles in the middle of the op -> Cnt frozen, StallM=FlushW=1, FlushM=0. Total StallE cycles = 5.
- Branch: BranchTakenE=1 with MemStall=0 -> FlushD=FlushE=1 and FlushEvents increments. The same input with MemStall=1 -> no flush until MemReadyM=1.
- Reset in MULTI with Cnt=1, then StallCycles forced to near saturation -> asynchronous reset gives IDLE and zeroed counters immediately. A separate run with CNT_W=4 shows the counter holding at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the five-stage pipeline hazard controller:
// forwarding select encodings and multi-cycle sequencer states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    MULTI = 1'b1
  } mc_state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding compare for a single Execute operand; the Memory-stage result
// wins over the Writeback-stage result when both match.
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [3:0] ra,
  input  logic [3:0] wa3m,
  input  logic [3:0] wa3w,
  input  logic       regwritem,
  input  logic       regwritew,
  output logic [1:0] fwd
);

  // operand source select, Memory first
  always_comb begin
    fwd = FWD_RF;
    if (regwritem && (wa3m == ra)) begin
      fwd = FWD_M;
    end else if (regwritew && (wa3w == ra)) begin
      fwd = FWD_W;
    end else begin
      fwd = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, stall/flush strobes,
// multi-cycle Execute sequencing and saturating stall/flush event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             BranchTakenE,
  input  logic             MultiCycleE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushEvents
);

  localparam int                CNT_BITS = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;
  localparam logic [CNT_BITS-1:0] MC_LOAD = CNT_BITS'(MC_LATENCY - 2);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  mc_state_t           state_r;
  mc_state_t           state_nxt_s;
  logic [CNT_BITS-1:0] cnt_r;
  logic [CNT_BITS-1:0] cnt_nxt_s;
  logic                mc_stall_s;
  logic                mem_stall_s;
  logic                ld_stall_s;
  logic [CNT_W-1:0]    stall_cycles_r;
  logic [CNT_W-1:0]    flush_events_r;

  fwd_unit u_fwd_a (
    .ra        (RA1E),
    .wa3m      (WA3M),
    .wa3w      (WA3W),
    .regwritem (RegWriteM),
    .regwritew (RegWriteW),
    .fwd       (ForwardAE)
  );

  fwd_unit u_fwd_b (
    .ra        (RA2E),
    .wa3m      (WA3M),
    .wa3w      (WA3W),
    .regwritem (RegWriteM),
    .regwritew (RegWriteW),
    .fwd       (ForwardBE)
  );

  assign mem_stall_s = MemReqM & ~MemReadyM;
  assign ld_stall_s  = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));

  // multi-cycle sequencer: next state, down-counter and McStall; frozen under MemStall
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    mc_stall_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (MultiCycleE && !mem_stall_s) begin
          mc_stall_s  = 1'b1;
          state_nxt_s = MULTI;
          cnt_nxt_s   = MC_LOAD;
        end else begin
          mc_stall_s  = 1'b0;
        end
      end
      MULTI: begin
        if (cnt_r != {CNT_BITS{1'b0}}) begin
          mc_stall_s = 1'b1;
          if (!mem_stall_s) begin
            cnt_nxt_s = cnt_r - CNT_BITS'(1);
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end else begin
          // release cycle: MultiCycleE is not sampled here
          mc_stall_s = 1'b0;
          if (!mem_stall_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = state_r;
          end
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_BITS{1'b0}};
        mc_stall_s  = 1'b0;
      end
    endcase
  end

  // sequencer state and down-counter registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_BITS{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // a taken branch overrides a load-use stall so the target fetch proceeds
  assign StallF = mem_stall_s | mc_stall_s | (ld_stall_s & ~BranchTakenE);
  assign StallD = StallF;
  assign StallE = mem_stall_s | mc_stall_s;
  assign StallM = mem_stall_s;
  assign FlushW = mem_stall_s;
  assign FlushM = mc_stall_s & ~mem_stall_s;
  assign FlushE = ~mem_stall_s & (ld_stall_s | BranchTakenE);
  assign FlushD = ~mem_stall_s & BranchTakenE;

  // saturating stall-cycle and branch-flush event counters
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_cycles_r <= {CNT_W{1'b0}};
      flush_events_r <= {CNT_W{1'b0}};
    end else begin
      if (StallF && (stall_cycles_r != CNT_MAX)) begin
        stall_cycles_r <= stall_cycles_r + CNT_W'(1);
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
      if (FlushD && (flush_events_r != CNT_MAX)) begin
        flush_events_r <= flush_events_r + CNT_W'(1);
      end else begin
        flush_events_r <= flush_events_r;
      end
    end
  end

  assign StallCycles = stall_cycles_r;
  assign FlushEvents = flush_events_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; a second instance with
// 4-bit counters exercises saturation.
module tb_hazard_ctrl;

  logic        CLK;
  logic        RESET;
  logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic        BranchTakenE, MultiCycleE, MemReqM, MemReadyM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM;
  logic        FlushD, FlushE, FlushM, FlushW;
  logic [31:0] StallCycles, FlushEvents;

  logic [1:0]  s_fae, s_fbe;
  logic        s_sf, s_sd, s_se, s_sm, s_fd, s_fe, s_fm, s_fw;
  logic [3:0]  s_stall_cycles, s_flush_events;

  int pass_cnt  = 0;
  int total_cnt = 0;

  hazard_ctrl #(.MC_LATENCY(4), .CNT_W(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE), .MultiCycleE(MultiCycleE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .StallCycles(StallCycles), .FlushEvents(FlushEvents)
  );

  hazard_ctrl #(.MC_LATENCY(4), .CNT_W(4)) dut_sat (
    .CLK(CLK), .RESET(RESET),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE), .MultiCycleE(MultiCycleE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(s_fae), .ForwardBE(s_fbe),
    .StallF(s_sf), .StallD(s_sd), .StallE(s_se), .StallM(s_sm),
    .FlushD(s_fd), .FlushE(s_fe), .FlushM(s_fm), .FlushW(s_fw),
    .StallCycles(s_stall_cycles), .FlushEvents(s_flush_events)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic clear_inputs();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    BranchTakenE = 1'b0; MultiCycleE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    RESET = 1'b1;
    #3;
    total_cnt++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW} !== 8'h00)
      $display("FAIL reset_strobes: got %b expected 00000000",
               {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW});
    else pass_cnt++;
    total_cnt++;
    if ({ForwardAE, ForwardBE} !== 4'b0000)
      $display("FAIL reset_fwd: got %b expected 0000", {ForwardAE, ForwardBE});
    else pass_cnt++;
    total_cnt++;
    if (StallCycles !== 32'd0 || FlushEvents !== 32'd0)
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", StallCycles, FlushEvents);
    else pass_cnt++;
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_forwarding();
    do_reset();
    RegWriteM = 1'b1; WA3M = 4'd3; RegWriteW = 1'b1; WA3W = 4'd3;
    RA1E = 4'd3; RA2E = 4'd5;
    #1;
    total_cnt++;
    if (ForwardAE !== 2'b10) $display("FAIL fwd_a_mem: got %b expected 10", ForwardAE);
    else pass_cnt++;
    total_cnt++;
    if (ForwardBE !== 2'b00) $display("FAIL fwd_b_none: got %b expected 00", ForwardBE);
    else pass_cnt++;
    RegWriteM = 1'b0;
    #1;
    total_cnt++;
    if (ForwardAE !== 2'b01) $display("FAIL fwd_a_wb: got %b expected 01", ForwardAE);
    else pass_cnt++;
    RegWriteM = 1'b1; WA3M = 4'd5; RegWriteW = 1'b0;
    #1;
    total_cnt++;
    if ({ForwardAE, ForwardBE} !== 4'b0010)
      $display("FAIL fwd_b_mem: got %b expected 0010", {ForwardAE, ForwardBE});
    else pass_cnt++;
  endtask

  task automatic test_load_use();
    do_reset();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd2; RA2D = 4'd2; RA1D = 4'd7;
    #1;
    total_cnt++;
    if ({StallF, StallD, FlushE, StallE, FlushD} !== 5'b11100)
      $display("FAIL load_use_strobes: got %b expected 11100", {StallF, StallD, FlushE, StallE, FlushD});
    else pass_cnt++;
    tick();
    clear_inputs();
    #1;
    total_cnt++;
    if (StallCycles !== 32'd1) $display("FAIL load_use_count: got %0d expected 1", StallCycles);
    else pass_cnt++;
    total_cnt++;
    if (StallF !== 1'b0) $display("FAIL load_use_clear: got %b expected 0", StallF);
    else pass_cnt++;
  endtask

  task automatic test_multicycle();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      MultiCycleE = (i < 4);
      #1;
      total_cnt++;
      if ({StallE, FlushM, StallF} !== {3{i < 3}})
        $display("FAIL mc_cycle%0d: got %b expected %b", i + 1, {StallE, FlushM, StallF}, {3{i < 3}});
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (StallCycles !== 32'd3) $display("FAIL mc_count: got %0d expected 3", StallCycles);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_se;
    exp_se = 8'b01110111;
    do_reset();
    MultiCycleE = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      total_cnt++;
      if (StallE !== exp_se[i]) $display("FAIL b2b_cycle%0d: got %b expected %b", i + 1, StallE, exp_se[i]);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_memstall_multi();
    logic [5:0] exp_se, exp_fm, exp_sm;
    int se_total;
    exp_se = 6'b011111;
    exp_fm = 6'b011001;
    exp_sm = 6'b000110;
    se_total = 0;
    do_reset();
    MultiCycleE = 1'b1; MemReqM = 1'b1;
    for (int i = 0; i < 6; i++) begin
      MemReadyM = !(i == 1 || i == 2);
      #1;
      if (StallE === 1'b1) se_total++;
      total_cnt++;
      if ({StallE, FlushM, StallM, FlushW} !== {exp_se[i], exp_fm[i], exp_sm[i], exp_sm[i]})
        $display("FAIL memstall_cycle%0d: got %b expected %b", i + 1,
                 {StallE, FlushM, StallM, FlushW}, {exp_se[i], exp_fm[i], exp_sm[i], exp_sm[i]});
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (se_total != 5) $display("FAIL memstall_total: got %0d expected 5", se_total);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    do_reset();
    BranchTakenE = 1'b1;
    #1;
    total_cnt++;
    if ({FlushD, FlushE, StallF} !== 3'b110)
      $display("FAIL branch_flush: got %b expected 110", {FlushD, FlushE, StallF});
    else pass_cnt++;
    tick();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total_cnt++;
      if ({FlushD, FlushE, StallM, StallF} !== 4'b0011)
        $display("FAIL branch_held%0d: got %b expected 0011", i, {FlushD, FlushE, StallM, StallF});
      else pass_cnt++;
      tick();
    end
    MemReadyM = 1'b1;
    #1;
    total_cnt++;
    if ({FlushD, FlushE} !== 2'b11) $display("FAIL branch_release: got %b expected 11", {FlushD, FlushE});
    else pass_cnt++;
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd4; RA1D = 4'd4;
    #1;
    total_cnt++;
    if ({FlushD, FlushE, StallF, StallD} !== 4'b1100)
      $display("FAIL branch_ld_override: got %b expected 1100", {FlushD, FlushE, StallF, StallD});
    else pass_cnt++;
    tick();
    clear_inputs();
    #1;
    total_cnt++;
    if (FlushEvents !== 32'd2 || StallCycles !== 32'd2)
      $display("FAIL branch_counts: got %0d/%0d expected 2/2", FlushEvents, StallCycles);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    MultiCycleE = 1'b1;
    tick();
    tick();
    MultiCycleE = 1'b0;
    #1;
    total_cnt++;
    if (StallE !== 1'b1 || StallCycles !== 32'd2)
      $display("FAIL mid_op_pre: got %b/%0d expected 1/2", StallE, StallCycles);
    else pass_cnt++;
    #1;
    RESET = 1'b1;
    #1;
    total_cnt++;
    if (StallE !== 1'b0 || StallCycles !== 32'd0 || FlushEvents !== 32'd0)
      $display("FAIL mid_op_async: got %b/%0d/%0d expected 0/0/0", StallE, StallCycles, FlushEvents);
    else pass_cnt++;
    tick();
    RESET = 1'b0;
    tick();
    total_cnt++;
    if (StallE !== 1'b0) $display("FAIL mid_op_idle: got %b expected 0", StallE);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    do_reset();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    repeat (20) tick();
    total_cnt++;
    if (StallCycles !== 32'd20) $display("FAIL sat_wide_stall: got %0d expected 20", StallCycles);
    else pass_cnt++;
    total_cnt++;
    if (s_stall_cycles !== 4'd15) $display("FAIL sat_stall: got %0d expected 15", s_stall_cycles);
    else pass_cnt++;
    clear_inputs();
    BranchTakenE = 1'b1;
    repeat (18) tick();
    total_cnt++;
    if (FlushEvents !== 32'd18) $display("FAIL sat_wide_flush: got %0d expected 18", FlushEvents);
    else pass_cnt++;
    total_cnt++;
    if (s_flush_events !== 4'd15 || s_stall_cycles !== 4'd15)
      $display("FAIL sat_hold: got %0d/%0d expected 15/15", s_flush_events, s_stall_cycles);
    else pass_cnt++;
  endtask

  initial begin
    clear_inputs();
    RESET = 1'b0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_multicycle();
    test_back_to_back();
    test_memstall_multi();
    test_branch();
    test_reset_mid_op();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
